imem_loader: RTL and testbench

//  Boot loader for the core's instruction RAM. It takes a byte stream over a valid/ready handshake, e.g. from a UART receiver.
//  It assembles little-endian 32-bit words and drives the IRAM write port (ADDR/DIN/wren) with them.
//  It holds the CPU in reset until the image is loaded, so the core is the reader of IRAM and this block is its writer.

---
 rtl/imem_loader.sv | 239 +++++++++++++++++++++++
 tb/tb_imem_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot loader for the core's instruction RAM. Bytes arrive over a valid/ready
// stream (typically a UART receiver). The loader assembles them into
// little-endian 32-bit words and writes them to the IRAM write port. The CPU
// is held in reset until a complete, well-formed image has been written.
//
// Frame: LEN_L, LEN_H (16-bit word count N), 4*N data bytes (first byte of a
// word lands in bits [7:0]), then an optional checksum byte.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   : an 8-bit running sum over LEN_L..last data byte is kept and a
//               trailing checksum byte must match it, otherwise ERR.
//   undefined : no checksum byte; the last data byte completes the load.
//
// Ports
//   clock        in   single clock, all state on its rising edge
//   reset        in   asynchronous active-high reset, clears all state
//   rx_data      in   stream byte
//   rx_valid     in   rx_data valid
//   rx_ready     out  loader accepts a byte (transfer = rx_valid & rx_ready)
//   rearm        in   restart a load from DONE/ERR, ignored in other states
//   mem_addr     out  IRAM word address
//   mem_din      out  IRAM write data
//   mem_wren     out  IRAM write strobe, single-cycle pulse
//   cpu_hold     out  1 = keep the core in reset
//   done         out  image loaded successfully, core released
//   error        out  load failed (length overflow or checksum mismatch)
//   words_loaded out  number of words written during this load
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              rearm,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int          DEPTH   = 1 << ADDR_W;
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR
    } state_t;
`endif

    state_t          state_reg;
    logic [7:0]      len_l_reg;
    // Only the low ADDR_W+1 bits of N are kept: anything larger than DEPTH
    // is rejected before it is stored.
    logic [ADDR_W:0] len_reg;
    logic [1:0]      lane_reg;

    logic            transfer;
    logic [15:0]     len_n;
    logic [ADDR_W:0] words_inc;
    logic            last_word;

    assign transfer  = rx_valid & rx_ready;
    assign len_n     = {rx_data, len_l_reg};
    assign words_inc = words_loaded + 1'b1;
    assign last_word = (words_inc == len_reg);

    // -------------------------------------------------------------------------
    // Byte lanes 0..2 of the word being assembled. Lane 3 is never stored: it
    // is taken straight from rx_data on the cycle the word completes, so the
    // write goes out without a bubble.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] byte_reg;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    byte_reg <= 8'h00;
                end else if (state_reg == S_DATA && transfer &&
                             lane_reg == 2'(gi)) begin
                    byte_reg <= rx_data;
                end
            end
        end
    endgenerate

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_reg;
`endif

    // -------------------------------------------------------------------------
    // Main FSM. rx_ready is registered and always set together with the
    // state it belongs to, so it is 1 exactly in the accepting states (and
    // 0 during the first cycle after reset while it is still being raised).
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= S_LEN0;
            len_l_reg    <= 8'h00;
            len_reg      <= '0;
            lane_reg     <= 2'd0;
            rx_ready     <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= '0;
            mem_wren     <= 1'b0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_reg      <= 8'h00;
`endif
        end else begin
            mem_wren <= 1'b0;

            case (state_reg)
                S_LEN0: begin
                    rx_ready <= 1'b1;
                    if (transfer) begin
                        len_l_reg <= rx_data;
                        state_reg <= S_LEN1;
                    end
                end

                S_LEN1: begin
                    if (transfer) begin
                        if ({1'b0, len_n} > DEPTH_L) begin
                            state_reg <= S_ERR;
                            rx_ready  <= 1'b0;
                            error     <= 1'b1;
                        end else if (len_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_reg <= S_CSUM;
`else
                            state_reg <= S_DONE;
                            rx_ready  <= 1'b0;
                            cpu_hold  <= 1'b0;
                            done      <= 1'b1;
`endif
                        end else begin
                            len_reg   <= len_n[ADDR_W:0];
                            lane_reg  <= 2'd0;
                            state_reg <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (transfer) begin
                        if (lane_reg == 2'd3) begin
                            mem_din      <= {rx_data, g_lane[2].byte_reg,
                                             g_lane[1].byte_reg,
                                             g_lane[0].byte_reg};
                            mem_addr     <= words_loaded[ADDR_W-1:0];
                            mem_wren     <= 1'b1;
                            words_loaded <= words_inc;
                            lane_reg     <= 2'd0;
                            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                                state_reg <= S_CSUM;
`else
                                state_reg <= S_DONE;
                                rx_ready  <= 1'b0;
                                cpu_hold  <= 1'b0;
                                done      <= 1'b1;
`endif
                            end
                        end else begin
                            lane_reg <= lane_reg + 2'd1;
                        end
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (transfer) begin
                        rx_ready <= 1'b0;
                        if (rx_data == sum_reg) begin
                            state_reg <= S_DONE;
                            cpu_hold  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            // Written words stay in IRAM but the core is
                            // never released on a bad image.
                            state_reg <= S_ERR;
                            error     <= 1'b1;
                        end
                    end
                end
`endif

                S_DONE, S_ERR: begin
                    rx_ready <= 1'b0;
                    if (rearm) begin
                        state_reg    <= S_LEN0;
                        rx_ready     <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        lane_reg     <= 2'd0;
                    end
                end

                default: begin
                    state_reg <= S_LEN0;
                    rx_ready  <= 1'b0;
                end
            endcase

`ifdef LOADER_CHECKSUM_EN
            // Running sum over the length and data bytes; restarts on rearm.
            // The two branches are exclusive: rearm is only seen in DONE/ERR
            // where no byte is accepted.
            if (transfer && (state_reg == S_LEN0 || state_reg == S_LEN1 ||
                             state_reg == S_DATA)) begin
                sum_reg <= sum_reg + rx_data;
            end else if (rearm &&
                         (state_reg == S_DONE || state_reg == S_ERR)) begin
                sum_reg <= 8'h00;
            end
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader. Stimulus pushes the expected IRAM writes
// into a queue; an independent monitor pops and compares on every mem_wren.
// Status outputs are checked directly by the stimulus process. Builds with or
// without LOADER_CHECKSUM_EN; the checksum byte is computed by the bench.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clock    = 1'b0;
    logic              reset    = 1'b1;
    logic [7:0]        rx_data  = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rearm    = 1'b0;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic              mem_wren;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rearm        (rearm),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_wren     (mem_wren),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] frm[$];
    int         errors = 0;
    int         checks = 0;
    int         writes = 0;
    int         w0;
    wr_t        mon_e;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every write must match the head of the queue.
    always @(negedge clock) begin
        if (!reset && mem_wren) begin
            writes++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected none",
                         mem_addr, mem_din);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                check("wr_data", mem_din, mon_e.data);
                $display("write addr=%h data=%h", mem_addr, mem_din);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Present one byte and hold it until it is accepted (bounded wait).
    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        while (!rx_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout: got rx_ready=0 expected 1 for byte %h", b);
        end
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    // Send frm with optional random idle gaps; appends the checksum byte
    // (optionally corrupted) when the feature is built in.
    task automatic send_frame(input int max_gap, input bit bad_csum);
        logic [7:0] sum;
        int         gap;
        sum = 8'h00;
        foreach (frm[i]) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (gap > 0) tick(gap);
            sum = sum + frm[i];
            send_byte(frm[i]);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad_csum ? (sum ^ 8'h01) : sum);
`else
        if (bad_csum) sum = 8'h00;
`endif
    endtask

    task automatic do_rearm();
        rearm = 1'b1;
        tick(1);
        rearm = 1'b0;
        check("rearm_rx_ready", 32'(rx_ready), 32'd1);
        check("rearm_done", 32'(done), 32'd0);
        check("rearm_error", 32'(error), 32'd0);
        check("rearm_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rearm_words", 32'(words_loaded), 32'd0);
    endtask

    task automatic load_t1();
        frm = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                8'h13, 8'h01, 8'h20, 8'h00};
        exp_q.push_back(wr_t'{addr: 8'h00, data: 32'h00100093});
        exp_q.push_back(wr_t'{addr: 8'h01, data: 32'h00200113});
    endtask

    task automatic check_done(input string tag, input int nwords);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'(nwords));
        check({tag, "_wr_count"}, 32'(writes - w0), 32'(nwords));
    endtask

    initial begin
        // Reset state
        tick(2);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_din", mem_din, 32'd0);
        check("rst_mem_wren", 32'(mem_wren), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b0;
        check("post_rst_rx_ready0", 32'(rx_ready), 32'd0);
        tick(1);
        check("post_rst_rx_ready1", 32'(rx_ready), 32'd1);

        // Two words
        $display("test two_words");
        w0 = writes;
        load_t1();
        send_frame(0, 1'b0);
        tick(2);
        check_done("t1", 2);

        // Empty image: done right after LEN_H (or after the checksum byte)
        $display("test empty_image");
        do_rearm();
        w0 = writes;
        frm = '{8'h00, 8'h00};
        send_frame(0, 1'b0);
        check("t2_done_early", 32'(done), 32'd1);
        tick(2);
        check_done("t2", 0);

        // Overflow: N = 257
        $display("test overflow");
        do_rearm();
        w0 = writes;
        send_byte(8'h01);
        send_byte(8'h01);
        tick(2);
        check("t3_error", 32'(error), 32'd1);
        check("t3_cpu_hold", 32'(cpu_hold), 32'd1);
        check("t3_rx_ready", 32'(rx_ready), 32'd0);
        check("t3_done", 32'(done), 32'd0);
        check("t3_wr_count", 32'(writes - w0), 32'd0);
        do_rearm();

        // Reset in the middle of a word
        $display("test reset_mid_frame");
        w0 = writes;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        tick(1);
        reset = 1'b1;
        tick(1);
        check("t4_rst_rx_ready", 32'(rx_ready), 32'd0);
        check("t4_rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b0;
        tick(1);
        check("t4_rx_ready", 32'(rx_ready), 32'd1);
        frm = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        exp_q.push_back(wr_t'{addr: 8'h00, data: 32'h44332211});
        send_frame(0, 1'b0);
        tick(2);
        check_done("t4", 1);

        // Backpressure: idle gaps between bytes
        $display("test gaps");
        do_rearm();
        w0 = writes;
        load_t1();
        send_frame(5, 1'b0);
        tick(2);
        check_done("t5", 2);

        // Full depth: 256 words, word i = four copies of byte i
        $display("test full_depth");
        do_rearm();
        w0 = writes;
        frm = '{8'h00, 8'h01};
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 4; k++) frm.push_back(8'(i));
            exp_q.push_back(wr_t'{addr: 8'(i), data: {4{8'(i)}}});
        end
        send_frame(0, 1'b0);
        tick(2);
        check_done("t6", 256);
        check("t6_last_addr", 32'(mem_addr), 32'h0000_00FF);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: words written, core stays held
        $display("test bad_checksum");
        do_rearm();
        w0 = writes;
        load_t1();
        send_frame(0, 1'b1);
        tick(2);
        check("t7_error", 32'(error), 32'd1);
        check("t7_cpu_hold", 32'(cpu_hold), 32'd1);
        check("t7_done", 32'(done), 32'd0);
        check("t7_wr_count", 32'(writes - w0), 32'd2);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
